// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle datapath and its control FSM.
//   Opcode    [5:0]  instruction[31:26] from the instruction register
//   Zero             ALU zero flag, only used while in BRANCH
//   PCEn             PC write enable
//   PCSrc     [1:0]  00 ALU result, 01 ALUOut, 10 jump address
//   IorD             memory address select (0 PC, 1 ALUOut)
//   MemRead/MemWrite/IRWrite/RegWrite  memory, IR and register-file strobes
//   RegDst           0 rt, 1 rd
//   MemtoReg         0 ALUOut, 1 MDR
//   ALUSrcA          0 PC, 1 A
//   ALUSrcB   [1:0]  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   ALUOp     [2:0]  000 ADD, 001 SUB, 010 OR, 011 LUI, 111 R-type
//   State     [3:0]  current FSM state code (debug)
//   IllegalOp        sticky unsupported-opcode flag
// slave modport: the controller; master modport: the datapath side.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PCEn;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic       IllegalOp;

    modport slave (
        input  Opcode, Zero,
        output PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, State, IllegalOp
    );

    modport master (
        output Opcode, Zero,
        input  PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, State, IllegalOp
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for a MIPS-style multicycle datapath (lw, sw, R-type,
// addi/ori/lui, beq, j). Outputs decode from the state register and the
// opcode latched when leaving DECODE; only PCEn in BRANCH looks at Zero
// combinationally.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    multicycle_control_if.slave (opcode/zero in, control strobes out)
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.slave    bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXE   = 4'd6,  S_RWB   = 4'd7,
        S_IEXE   = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_opreg;
    logic       r_illegal;

    logic       w_pcen, w_iord, w_memread, w_memwrite, w_irwrite;
    logic       w_regwrite, w_regdst, w_memtoreg, w_alusrca;
    logic [1:0] w_pcsrc, w_alusrcb;
    logic [2:0] w_aluop;

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI,
            OP_ORI, OP_LUI, OP_BEQ, OP_J:    ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register, opcode latch and sticky illegal-opcode flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_opreg   <= 6'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Opcode is only trusted on the edge leaving DECODE; later
            // states work from the latched copy.
            if (r_state == S_DECODE) begin
                r_opreg <= bus.Opcode;
                if (!op_supported(bus.Opcode)) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_RTYPE:                w_next_state = S_REXE;
                    OP_LW, OP_SW:            w_next_state = S_MEMADR;
                    OP_ADDI, OP_ORI, OP_LUI: w_next_state = S_IEXE;
                    OP_BEQ:                  w_next_state = S_BRANCH;
                    OP_J:                    w_next_state = S_JUMP;
                    default:                 w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (r_opreg == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_REXE:   w_next_state = S_RWB;
            S_IEXE:   w_next_state = S_IWB;
            default:  w_next_state = S_FETCH;   // completions and codes 12-15
        endcase
    end

    // Moore output decode; codes 12-15 fall to the all-zero default.
    always_comb begin
        w_pcen = 1'b0;  w_pcsrc = 2'b00;  w_iord = 1'b0;
        w_memread = 1'b0;  w_memwrite = 1'b0;  w_irwrite = 1'b0;
        w_regwrite = 1'b0; w_regdst = 1'b0;    w_memtoreg = 1'b0;
        w_alusrca = 1'b0;  w_alusrcb = 2'b00;  w_aluop = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1; w_irwrite = 1'b1; w_alusrcb = 2'b01; w_pcen = 1'b1;
            end
            S_DECODE: w_alusrcb = 2'b11;   // precompute branch target
            S_MEMADR: begin
                w_alusrca = 1'b1; w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_iord = 1'b1; w_memread = 1'b1;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1; w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_iord = 1'b1; w_memwrite = 1'b1;
            end
            S_REXE: begin
                w_alusrca = 1'b1; w_aluop = 3'b111;
            end
            S_RWB: begin
                w_regdst = 1'b1; w_regwrite = 1'b1;
            end
            S_IEXE: begin
                w_alusrca = 1'b1; w_alusrcb = 2'b10;
                case (r_opreg)
                    OP_ORI:  w_aluop = 3'b010;
                    OP_LUI:  w_aluop = 3'b011;
                    default: w_aluop = 3'b000;
                endcase
            end
            S_IWB:    w_regwrite = 1'b1;
            S_BRANCH: begin
                w_alusrca = 1'b1; w_aluop = 3'b001; w_pcsrc = 2'b01;
                w_pcen = bus.Zero;   // the one Mealy term
            end
            S_JUMP: begin
                w_pcsrc = 2'b10; w_pcen = 1'b1;
            end
            default: w_pcen = 1'b0;
        endcase
    end

    // While reset is held the FETCH decode is shown but nothing is strobed.
    assign bus.PCEn      = w_pcen    & ~reset;
    assign bus.MemRead   = w_memread & ~reset;
    assign bus.IRWrite   = w_irwrite & ~reset;
    assign bus.PCSrc     = w_pcsrc;
    assign bus.IorD      = w_iord;
    assign bus.MemWrite  = w_memwrite;
    assign bus.RegWrite  = w_regwrite;
    assign bus.RegDst    = w_regdst;
    assign bus.MemtoReg  = w_memtoreg;
    assign bus.ALUSrcA   = w_alusrca;
    assign bus.ALUSrcB   = w_alusrcb;
    assign bus.ALUOp     = w_aluop;
    assign bus.State     = r_state;
    assign bus.IllegalOp = r_illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench: an instruction-level model (class + step within the
// instruction) predicts every output on each falling edge; directed literal
// checks pin state sequences, cycle counts and reset behaviour.
// -----------------------------------------------------------------------------
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if bus ();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_ORI, C_LUI, C_BEQ, C_J, C_ILL} cls_t;

    typedef struct packed {
        logic       pcen;
        logic [1:0] pcsrc;
        logic       iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [3:0] state;
        logic       illegal;
    } outs_t;

    // Instruction class from the opcode.
    function automatic cls_t classify(input logic [5:0] op);
        cls_t c;
        case (op)
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000000: c = C_R;
            6'b001000: c = C_ADDI;
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b000100: c = C_BEQ;
            6'b000010: c = C_J;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    // Cycles per instruction including FETCH.
    function automatic int cpi(input cls_t c);
        int n;
        case (c)
            C_LW:                  n = 5;
            C_SW, C_R:             n = 4;
            C_ADDI, C_ORI, C_LUI:  n = 4;
            C_BEQ, C_J:            n = 3;
            default:               n = 2;
        endcase
        return n;
    endfunction

    // Expected outputs for step k of an instruction of class c.
    function automatic outs_t expect_outs(input cls_t c, input int k, input logic z, input logic ill);
        outs_t o;
        o = '0;
        o.illegal = ill;
        if (k == 0) begin
            o.memread = 1'b1; o.irwrite = 1'b1; o.alusrcb = 2'b01; o.pcen = 1'b1; o.state = 4'd0;
        end else if (k == 1) begin
            o.alusrcb = 2'b11; o.state = 4'd1;
        end else begin
            case (c)
                C_LW, C_SW: begin
                    if (k == 2) begin
                        o.state = 4'd2; o.alusrca = 1'b1; o.alusrcb = 2'b10;
                    end else if (c == C_SW) begin
                        o.state = 4'd5; o.iord = 1'b1; o.memwrite = 1'b1;
                    end else if (k == 3) begin
                        o.state = 4'd3; o.iord = 1'b1; o.memread = 1'b1;
                    end else begin
                        o.state = 4'd4; o.memtoreg = 1'b1; o.regwrite = 1'b1;
                    end
                end
                C_R: begin
                    if (k == 2) begin
                        o.state = 4'd6; o.alusrca = 1'b1; o.aluop = 3'b111;
                    end else begin
                        o.state = 4'd7; o.regdst = 1'b1; o.regwrite = 1'b1;
                    end
                end
                C_ADDI, C_ORI, C_LUI: begin
                    if (k == 2) begin
                        o.state = 4'd8; o.alusrca = 1'b1; o.alusrcb = 2'b10;
                        o.aluop = (c == C_ORI) ? 3'b010 : (c == C_LUI) ? 3'b011 : 3'b000;
                    end else begin
                        o.state = 4'd9; o.regwrite = 1'b1;
                    end
                end
                C_BEQ: begin
                    o.state = 4'd10; o.alusrca = 1'b1; o.aluop = 3'b001;
                    o.pcsrc = 2'b01; o.pcen = z;
                end
                C_J: begin
                    o.state = 4'd11; o.pcsrc = 2'b10; o.pcen = 1'b1;
                end
                default: o.state = 4'd15;
            endcase
        end
        return o;
    endfunction

    // Instruction-level model: step within instruction, class, sticky flag.
    int   m_step;
    cls_t m_cls;
    logic m_ill;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_step <= 0;
            m_cls  <= C_ILL;
            m_ill  <= 1'b0;
        end else if (m_step == 1) begin
            m_cls  <= classify(bus.Opcode);
            if (classify(bus.Opcode) == C_ILL) m_ill <= 1'b1;
            m_step <= (cpi(classify(bus.Opcode)) > 2) ? 2 : 0;
        end else if (m_step == 0) begin
            m_step <= 1;
        end else begin
            m_step <= (m_step + 1 >= cpi(m_cls)) ? 0 : m_step + 1;
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        outs_t act, exp_o;
        act.pcen = bus.PCEn;         act.pcsrc = bus.PCSrc;       act.iord = bus.IorD;
        act.memread = bus.MemRead;   act.memwrite = bus.MemWrite; act.irwrite = bus.IRWrite;
        act.regwrite = bus.RegWrite; act.regdst = bus.RegDst;     act.memtoreg = bus.MemtoReg;
        act.alusrca = bus.ALUSrcA;   act.alusrcb = bus.ALUSrcB;   act.aluop = bus.ALUOp;
        act.state = bus.State;       act.illegal = bus.IllegalOp;
        if (reset) begin
            exp_o = expect_outs(C_ILL, 0, 1'b0, 1'b0);
            exp_o.memread = 1'b0; exp_o.irwrite = 1'b0; exp_o.pcen = 1'b0;
        end else begin
            exp_o = expect_outs(m_cls, m_step, bus.Zero, m_ill);
        end
        checks++;
        if (act !== exp_o) begin
            errors++;
            $display("FAIL model_cycle t=%0t got %h want %h", $time, act, exp_o);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int lw_seq[5];
    logic [5:0] op_tab[5];
    int cpi_tab[5];
    int n;

    initial begin
        lw_seq  = '{1, 2, 3, 4, 0};
        op_tab  = '{6'b101011, 6'b000000, 6'b001000, 6'b001111, 6'b000010};
        cpi_tab = '{4, 4, 4, 4, 3};

        reset = 1'b1;
        bus.Opcode = 6'b100011;
        bus.Zero = 1'b0;
        tick(); tick();
        chk("rst_state",   32'(bus.State),   32'd0);
        chk("rst_memread", 32'(bus.MemRead), 32'd0);
        chk("rst_pcen",    32'(bus.PCEn),    32'd0);
        chk("rst_irwrite", 32'(bus.IRWrite), 32'd0);
        chk("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
        chk("rst_illegal", 32'(bus.IllegalOp), 32'd0);
        reset = 1'b0;

        // lw: 0,1,2,3,4,0
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lw_state", 32'(bus.State), 32'(lw_seq[i]));
            if (i == 2) chk("lw_memread", 32'(bus.MemRead), 32'd1);
            if (i == 3) chk("lw_wb", {30'd0, bus.RegWrite, bus.MemtoReg}, 32'd3);
        end

        // beq taken, then not taken
        for (int z = 1; z >= 0; z--) begin
            bus.Opcode = 6'b000100;
            bus.Zero = z[0];
            tick(); chk("beq_decode", 32'(bus.State), 32'd1);
            tick(); chk("beq_state", 32'(bus.State), 32'd10);
            chk("beq_pcen", 32'(bus.PCEn), 32'(z));
            chk("beq_pcsrc", 32'(bus.PCSrc), 32'd1);
            tick(); chk("beq_done", 32'(bus.State), 32'd0);
        end

        // ori with opcode changed after DECODE
        bus.Opcode = 6'b001101;
        tick(); chk("ori_decode", 32'(bus.State), 32'd1);
        tick(); chk("ori_iexe", 32'(bus.State), 32'd8);
        chk("ori_aluop", 32'(bus.ALUOp), 32'd2);
        bus.Opcode = 6'b000000;
        tick(); chk("ori_iwb", 32'(bus.State), 32'd9);
        chk("ori_wb", {30'd0, bus.RegWrite, bus.RegDst}, 32'd2);
        tick(); chk("ori_done", 32'(bus.State), 32'd0);

        // cycle counts, opcode scrambled mid-instruction
        for (int i = 0; i < 5; i++) begin
            bus.Opcode = op_tab[i];
            n = 0;
            do begin
                tick();
                n++;
                if (n == 2) bus.Opcode = ~op_tab[i];
            end while (bus.State != 4'd0 && n < 10);
            chk("cpi", 32'(n), 32'(cpi_tab[i]));
        end

        // illegal opcode: 0,1,0 and sticky flag
        bus.Opcode = 6'b111111;
        tick(); chk("ill_decode", 32'(bus.State), 32'd1);
        chk("ill_flag_pre", 32'(bus.IllegalOp), 32'd0);
        tick(); chk("ill_fetch", 32'(bus.State), 32'd0);
        chk("ill_flag", 32'(bus.IllegalOp), 32'd1);
        bus.Opcode = 6'b000010;
        tick(); tick(); tick();
        chk("ill_sticky", 32'(bus.IllegalOp), 32'd1);

        // reset pulse in MEMRD
        bus.Opcode = 6'b100011;
        tick(); tick(); tick();
        chk("mr_state", 32'(bus.State), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("mr_rst_state",   32'(bus.State),     32'd0);
        chk("mr_rst_memread", 32'(bus.MemRead),   32'd0);
        chk("mr_rst_illegal", 32'(bus.IllegalOp), 32'd0);
        tick();
        reset = 1'b0;
        tick(); chk("mr_after_decode", 32'(bus.State), 32'd1);
        tick(); tick(); tick(); tick();
        chk("mr_after_done", 32'(bus.State), 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
